// File: rtl/dmem_arbiter_if.sv
// dmem_arbiter_if
//   Bundles the two requester ports and the data memory port of the
//   MEM-stage data memory arbiter.
//
//   Requester port N (N = 0 core MEM stage, N = 1 loader/debug):
//     pN_req, pN_we, pN_addr, pN_wdata  : request side, driven by the requester
//     pN_ack, pN_rdata                  : one-cycle completion and read data
//   Memory port (Mem_Data, 2048x32, registered read):
//     mem_addr, mem_data_in, mem_read, mem_write : driven by the arbiter
//     mem_data_out                                : registered read data from memory
//
//   Modports:
//     slave  : the arbiter's view
//     master : the environment's view (requesters plus memory)

interface dmem_arbiter_if #(
  parameter int ADDR_W = 11,
  parameter int DATA_W = 32
);

  logic              p0_req;
  logic              p0_we;
  logic [ADDR_W-1:0] p0_addr;
  logic [DATA_W-1:0] p0_wdata;
  logic              p0_ack;
  logic [DATA_W-1:0] p0_rdata;

  logic              p1_req;
  logic              p1_we;
  logic [ADDR_W-1:0] p1_addr;
  logic [DATA_W-1:0] p1_wdata;
  logic              p1_ack;
  logic [DATA_W-1:0] p1_rdata;

  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_data_in;
  logic [DATA_W-1:0] mem_data_out;
  logic              mem_read;
  logic              mem_write;

  modport slave (
    input  p0_req, p0_we, p0_addr, p0_wdata,
    output p0_ack, p0_rdata,
    input  p1_req, p1_we, p1_addr, p1_wdata,
    output p1_ack, p1_rdata,
    output mem_addr, mem_data_in, mem_read, mem_write,
    input  mem_data_out
  );

  modport master (
    output p0_req, p0_we, p0_addr, p0_wdata,
    input  p0_ack, p0_rdata,
    output p1_req, p1_we, p1_addr, p1_wdata,
    input  p1_ack, p1_rdata,
    input  mem_addr, mem_data_in, mem_read, mem_write,
    output mem_data_out
  );

endinterface

// File: rtl/dmem_arbiter.sv
// dmem_arbiter
//   Two-requester arbiter and sequencer for the 2048x32 data memory in the
//   MEM stage. Each access takes three cycles: IDLE (arbitrate and latch),
//   ISSUE (drive memRead/memWrite for one cycle), RESP (one-cycle ack with
//   the memory's registered read data, or zero for a write).
//
//   Ports:
//     clk       : system clock, all logic on posedge
//     rst       : synchronous active-high reset
//     bus       : dmem_arbiter_if.slave (requester ports 0/1 and memory port)
//     busy      : high whenever the FSM is not in IDLE
//     grant_id  : port currently or most recently granted
//
//   Optional feature:
//     DMEM_ARB_RR_EN : when defined, ties are broken by a 1-bit round-robin
//                      pointer; when undefined, port 0 always wins a tie.

module dmem_arbiter #(
  parameter int ADDR_W = 11,
  parameter int DATA_W = 32
) (
  input  logic           clk,
  input  logic           rst,
  dmem_arbiter_if.slave  bus,
  output logic           busy,
  output logic           grant_id
);

  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

  state_t            state;
  state_t            state_next;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic              grant_q;
  logic              any_req;
  logic              winner;

`ifdef DMEM_ARB_RR_EN
  logic              rr_ptr;

  // A tie goes to the port named by the pointer; a lone requester wins outright.
  always_comb begin
    any_req = bus.p0_req | bus.p1_req;
    if (bus.p0_req && bus.p1_req) begin
      winner = rr_ptr;
    end else begin
      winner = !bus.p0_req;
    end
  end

  // After every grant the pointer moves to the port that lost.
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr <= 1'b0;
    end else if (state == IDLE && any_req) begin
      rr_ptr <= !winner;
    end
  end
`else
  // Fixed priority: port 0 wins whenever it is requesting.
  always_comb begin
    any_req = bus.p0_req | bus.p1_req;
    winner  = !bus.p0_req;
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // The winner's request is frozen here so later changes on the request
  // lines cannot disturb an access already in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      grant_q <= 1'b0;
    end else if (state == IDLE && any_req) begin
      we_q    <= winner ? bus.p1_we    : bus.p0_we;
      addr_q  <= winner ? bus.p1_addr  : bus.p0_addr;
      wdata_q <= winner ? bus.p1_wdata : bus.p0_wdata;
      grant_q <= winner;
    end
  end

  // Memory strobes and acks are gated by rst combinationally, so a reset
  // landing on the ISSUE cycle suppresses the write and a reset landing on
  // the RESP cycle suppresses the ack.
  always_comb begin
    state_next      = state;
    bus.mem_addr    = addr_q;
    bus.mem_data_in = wdata_q;
    bus.mem_read    = 1'b0;
    bus.mem_write   = 1'b0;
    bus.p0_ack      = 1'b0;
    bus.p1_ack      = 1'b0;
    bus.p0_rdata    = '0;
    bus.p1_rdata    = '0;
    busy            = (state != IDLE);
    grant_id        = grant_q;

    case (state)
      IDLE: begin
        if (any_req) begin
          state_next = ISSUE;
        end
      end
      ISSUE: begin
        bus.mem_read  = !we_q && !rst;
        bus.mem_write = we_q && !rst;
        state_next    = RESP;
      end
      RESP: begin
        bus.p0_ack = !grant_q && !rst;
        bus.p1_ack = grant_q && !rst;
        if (!grant_q && !rst && !we_q) begin
          bus.p0_rdata = bus.mem_data_out;
        end
        if (grant_q && !rst && !we_q) begin
          bus.p1_rdata = bus.mem_data_out;
        end
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Two-requester arbiter and sequencer for the 2048x32 data memory (Mem_Data) in the MEM stage.
- Port 0 is the core MEM-stage access; port 1 is the program/data loader or debug port.
- Serialises both requesters onto the single memory port and generates memRead/memWrite.
- Captures the memory's registered read data and returns it with a one-cycle ack.

Parameters:
ADDR_W, 11, memory word address width (2048 words)
DATA_W, 32, data word width

Ports:
clk  in  1  system clock, all logic on posedge
rst  in  1  synchronous active-high reset
p0_req  in  1  port 0 request; held high until and including its ack cycle
p0_we  in  1  port 0 write enable (1 = write, 0 = read)
p0_addr  in  ADDR_W  port 0 word address
p0_wdata  in  DATA_W  port 0 write data
p0_ack  out  1  port 0 completion, one-cycle pulse
p0_rdata  out  DATA_W  port 0 read data, valid while p0_ack=1
p1_req, p1_we, p1_addr, p1_wdata, p1_ack, p1_rdata  same as port 0, for port 1
mem_addr  out  ADDR_W  to Mem_Data addr
mem_data_in  out  DATA_W  to Mem_Data data_in
mem_data_out  in  DATA_W  from Mem_Data data_out (registered, 1-cycle latency)
mem_read  out  1  to Mem_Data memRead
mem_write  out  1  to Mem_Data memWrite
busy  out  1  high in any state other than IDLE
grant_id  out  1  port currently or last granted

Behaviour:
- Clock is clk. Reset is synchronous and active-high (rst), sampled on posedge clk.
- FSM states: IDLE, ISSUE, RESP.
- IDLE:
  - If any req is high, select a winner.
  - Latch winner's we/addr/wdata into internal registers, set grant_id, go to ISSUE.
  - Otherwise stay in IDLE.
- ISSUE, exactly one cycle:
  - mem_addr = latched addr.
  - mem_read = !we_q & !rst.
  - mem_write = we_q & !rst.
  - mem_data_in = latched wdata.
  - Then go to RESP.
- RESP, exactly one cycle:
  - ack of the granted port = 1.
  - Granted rdata = mem_data_out for a read, 0 for a write.
  - Then go to IDLE.
- Latency: req sampled in cycle N, memory op at end of N+1, ack in N+2. Throughput is one access per 3 cycles.
- Requesters drop req at the edge ending their ack cycle. A req still high in the following IDLE cycle is treated as a new access.
- Arbitration without the optional feature: fixed priority, port 0 wins simultaneous requests.
- Requests changing after the latch are ignored until the next IDLE.
- Outputs outside ISSUE: mem_read=0, mem_write=0. mem_addr and mem_data_in hold the latched values (no glitch requirement).
- Non-granted port: ack=0, rdata=0. rdata is 0 whenever its ack is 0.
- Reset values: state=IDLE, busy=0, grant_id=0, p0_ack=p1_ack=0, p0_rdata=p1_rdata=0, mem_read=mem_write=0, latched addr/wdata/we=0, rr pointer=0.
- Reset mid-operation: abort to IDLE with no ack. Because of the combinational !rst gating, a write in an ISSUE cycle coinciding with rst=1 is NOT committed.
- Address boundary: addresses are used unmodified (0..2047). There is no wrap or range check.

Optional Feature:
- Macro: DMEM_ARB_RR_EN.
- Defined: round-robin arbitration.
  - A 1-bit pointer names the preferred port on a tie.
  - After each grant, the pointer is set to the non-granted port.
  - A lone requester always wins regardless of the pointer.
  - Pointer resets to 0 (port 0 preferred).
- Undefined: fixed priority, port 0 always wins ties; the pointer logic is absent.

Test Plan:
- p0 write addr 0x005 data 0xDEADBEEF, then p0 read 0x005 -> mem_write high one cycle in ISSUE; read p0_ack 2 cycles after req with p0_rdata=0xDEADBEEF; p1_ack stays 0.
- p0 read and p1 read asserted same cycle, addr 0x001 and 0x000 -> fixed priority: p0 acked first with 0x00000001; p1 acked 3 cycles later with 0x00000000.
- Same as previous with DMEM_ARB_RR_EN, both reqs held for 4 transactions -> grants alternate p0,p1,p0,p1; grant_id toggles accordingly.
- p1 write addr 0x7FF data 0x12345678, read back -> p1_rdata=0x12345678. Address 0x000 is unchanged (reads 0).
- rst asserted during ISSUE of a p0 write to 0x010 data 0xAAAA5555 -> no ack, FSM in IDLE next cycle, busy=0; later read of 0x010 returns 0.
- Back-to-back p0 accesses with req held continuously -> second access starts in the IDLE cycle after ack; 3-cycle spacing between acks.
